// File: rtl/card_draw_scheduler.sv
// Arbitrates player/dealer draw requests onto one shared card source, with
// bounded retry on out-of-range cards, shoe counting and a timed reshuffle.
module card_draw_scheduler #(
  parameter int unsigned SRC_LAT        = 2,
  parameter int unsigned SHOE_SIZE      = 52,
  parameter int unsigned SHUFFLE_CYCLES = 8,
  parameter int unsigned MAX_RETRY      = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       req_p,
  input  logic       req_d,
  input  logic       new_shoe,
  input  logic [3:0] src_card,
  output logic       src_on,
  output logic [3:0] card_out,
  output logic       valid_p,
  output logic       valid_d,
  output logic       busy,
  output logic       shuffle_busy,
  output logic [5:0] dealt_cnt,
  output logic       retry_err
);

  localparam int unsigned LAT_W = (SRC_LAT > 1) ? $clog2(SRC_LAT) : 1;
  localparam int unsigned RTY_W = (MAX_RETRY > 1) ? $clog2(MAX_RETRY) : 1;
  localparam int unsigned SHF_W = (SHUFFLE_CYCLES > 1) ? $clog2(SHUFFLE_CYCLES) : 1;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ISSUE   = 3'd1,
    S_WAIT    = 3'd2,
    S_DELIVER = 3'd3,
    S_SHUFFLE = 3'd4
  } state_t;

  state_t             state_q, state_d;
  logic               pend_p_q, pend_p_d;
  logic               pend_d_q, pend_d_d;
  logic               pend_shuf_q, pend_shuf_d;
  logic               owner_q, owner_d;      // 1 = dealer
  logic               last_q, last_d;        // last granted, 1 = dealer
  logic [RTY_W-1:0]   retry_q, retry_d;
  logic [LAT_W-1:0]   lat_q, lat_d;
  logic [SHF_W-1:0]   shf_q, shf_d;
  logic [3:0]         card_q, card_d;
  logic               err_q, err_d;
  logic [5:0]         dealt_q, dealt_d;

  logic shoe_full, want_shuf, card_ok, lat_done, shf_done, last_try, go_issue, grant;

  always_comb begin
    shoe_full = (dealt_q == 6'(SHOE_SIZE));
    want_shuf = pend_shuf_q || shoe_full;
    card_ok   = (src_card >= 4'd1) && (src_card <= 4'd10);
    lat_done  = (lat_q == LAT_W'(SRC_LAT - 1));
    shf_done  = (shf_q == SHF_W'(SHUFFLE_CYCLES - 1));
    last_try  = (retry_q == RTY_W'(MAX_RETRY - 1));
    go_issue  = (state_q == S_IDLE) && !want_shuf && (pend_p_q || pend_d_q);
    // On contention the requester that was not served last wins
    if (pend_p_q && pend_d_q) grant = ~last_q;
    else                      grant = pend_d_q;
  end

  // State register
  always_ff @(posedge clk) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (want_shuf)                 state_d = S_SHUFFLE;
        else if (pend_p_q || pend_d_q) state_d = S_ISSUE;
      end
      S_ISSUE: state_d = S_WAIT;
      S_WAIT: begin
        if (lat_done) state_d = (card_ok || last_try) ? S_DELIVER : S_ISSUE;
      end
      S_DELIVER: state_d = S_IDLE;
      S_SHUFFLE: begin
        if (shf_done) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath next values
  always_comb begin
    owner_d     = go_issue ? grant : owner_q;
    last_d      = (state_q == S_DELIVER) ? owner_q : last_q;
    pend_p_d    = pend_p_q ? !(go_issue && !grant) : req_p;
    pend_d_d    = pend_d_q ? !(go_issue && grant) : req_d;
    pend_shuf_d = pend_shuf_q ? !((state_q == S_SHUFFLE) && shf_done) : new_shoe;
    lat_d       = ((state_q == S_WAIT) && !lat_done) ? lat_q + 1'b1 : '0;
    shf_d       = ((state_q == S_SHUFFLE) && !shf_done) ? shf_q + 1'b1 : '0;
    retry_d     = retry_q;
    card_d      = card_q;
    err_d       = err_q;
    dealt_d     = dealt_q;
    if (go_issue) retry_d = '0;
    if ((state_q == S_WAIT) && lat_done) begin
      if (card_ok) begin
        card_d = src_card;
      end else if (last_try) begin
        card_d = 4'd10;
        err_d  = 1'b1;
      end else begin
        retry_d = retry_q + 1'b1;
      end
    end
    if ((state_q == S_DELIVER) && !shoe_full) dealt_d = dealt_q + 6'd1;
    if ((state_q == S_SHUFFLE) && shf_done)   dealt_d = '0;
  end

  // Datapath registers
  always_ff @(posedge clk) begin
    if (reset) begin
      pend_p_q    <= 1'b0;
      pend_d_q    <= 1'b0;
      pend_shuf_q <= 1'b0;
      owner_q     <= 1'b0;
      last_q      <= 1'b1;
      retry_q     <= '0;
      lat_q       <= '0;
      shf_q       <= '0;
      card_q      <= 4'd0;
      err_q       <= 1'b0;
      dealt_q     <= 6'd0;
    end else begin
      pend_p_q    <= pend_p_d;
      pend_d_q    <= pend_d_d;
      pend_shuf_q <= pend_shuf_d;
      owner_q     <= owner_d;
      last_q      <= last_d;
      retry_q     <= retry_d;
      lat_q       <= lat_d;
      shf_q       <= shf_d;
      card_q      <= card_d;
      err_q       <= err_d;
      dealt_q     <= dealt_d;
    end
  end

  // Outputs decoded from registered state
  always_comb begin
    src_on       = (state_q == S_ISSUE);
    valid_p      = (state_q == S_DELIVER) && !owner_q;
    valid_d      = (state_q == S_DELIVER) && owner_q;
    busy         = (state_q != S_IDLE);
    shuffle_busy = (state_q == S_SHUFFLE);
    card_out     = card_q;
    dealt_cnt    = dealt_q;
    retry_err    = err_q;
  end

endmodule

// File: tb/tb_card_draw_scheduler.sv
// Directed bench for card_draw_scheduler (small shoe of 4 to reach reshuffle quickly).
module tb_card_draw_scheduler;

  logic       clk = 1'b0;
  logic       reset, req_p, req_d, new_shoe;
  logic [3:0] src_card;
  logic       src_on, valid_p, valid_d, busy, shuffle_busy, retry_err;
  logic [3:0] card_out;
  logic [5:0] dealt_cnt;

  int total = 0;
  int bad   = 0;
  int on_cnt, shuf_cnt, n, vacc, on0;
  logic [3:0] src_q[$];

  card_draw_scheduler #(.SRC_LAT(2), .SHOE_SIZE(4), .SHUFFLE_CYCLES(8), .MAX_RETRY(3)) dut (
    .clk(clk), .reset(reset), .req_p(req_p), .req_d(req_d), .new_shoe(new_shoe),
    .src_card(src_card), .src_on(src_on), .card_out(card_out), .valid_p(valid_p),
    .valid_d(valid_d), .busy(busy), .shuffle_busy(shuffle_busy), .dealt_cnt(dealt_cnt),
    .retry_err(retry_err)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // One clock; strobes last one cycle, source answers each src_on from the queue
  task automatic step;
    @(posedge clk);
    #1;
    req_p = 1'b0; req_d = 1'b0; new_shoe = 1'b0;
    if (src_on) begin
      on_cnt++;
      if (src_q.size() != 0) src_card = src_q.pop_front();
    end
    if (shuffle_busy) shuf_cnt++;
  endtask

  task automatic wait_valid(input int max, output int cyc);
    cyc = 0;
    do begin
      step();
      cyc++;
    end while (!(valid_p || valid_d) && cyc < max);
    if (!(valid_p || valid_d)) check_eq("valid_timeout", 0, 1);
  endtask

  task automatic do_reset;
    reset = 1'b1; req_p = 1'b0; req_d = 1'b0; new_shoe = 1'b0; src_card = 4'd0;
    src_q.delete();
    step(); step();
    reset = 1'b0;
  endtask

  initial begin
    do_reset();
    check_eq("rst_busy", busy, 0);
    check_eq("rst_src_on", src_on, 0);
    check_eq("rst_valid", valid_p | valid_d, 0);
    check_eq("rst_card", card_out, 0);
    check_eq("rst_dealt", dealt_cnt, 0);
    check_eq("rst_err", retry_err, 0);

    // T1 single player draw, exact cycle timing
    src_q = '{4'd7};
    req_p = 1'b1;
    step();  check_eq("t1_c1_src_on", src_on, 0);
    step();  check_eq("t1_c2_src_on", src_on, 1);
    check_eq("t1_c2_busy", busy, 1);
    step();  step();
    check_eq("t1_c4_valid", valid_p, 0);
    step();
    check_eq("t1_c5_valid_p", valid_p, 1);
    check_eq("t1_c5_valid_d", valid_d, 0);
    check_eq("t1_c5_card", card_out, 7);
    step();
    check_eq("t1_c6_dealt", dealt_cnt, 1);
    check_eq("t1_c6_busy", busy, 0);
    check_eq("t1_c6_valid", valid_p, 0);

    // T2 simultaneous requests, round robin starts with player
    do_reset();
    src_q = '{4'd3, 4'd9, 4'd4, 4'd6};
    req_p = 1'b1; req_d = 1'b1;
    wait_valid(40, n);
    check_eq("t2_first_p", valid_p, 1);
    check_eq("t2_first_card", card_out, 3);
    wait_valid(40, n);
    check_eq("t2_second_d", valid_d, 1);
    check_eq("t2_second_p", valid_p, 0);
    check_eq("t2_second_card", card_out, 9);
    step();
    req_p = 1'b1; req_d = 1'b1;
    wait_valid(40, n);
    check_eq("t2_rep_first_p", valid_p, 1);
    check_eq("t2_rep_card", card_out, 4);
    wait_valid(40, n);
    check_eq("t2_rep_second_d", valid_d, 1);
    check_eq("t2_rep_card2", card_out, 6);

    // T3 retries then good card; then forced card after repeated bad draws
    do_reset();
    src_q = '{4'd0, 4'd12, 4'd5};
    on_cnt = 0;
    req_p = 1'b1;
    wait_valid(60, n);
    check_eq("t3_latency", n, 11);
    check_eq("t3_src_on_cnt", on_cnt, 3);
    check_eq("t3_card", card_out, 5);
    check_eq("t3_err_clear", retry_err, 0);
    step();
    src_q = '{4'd15, 4'd15, 4'd15, 4'd15};
    on_cnt = 0;
    req_d = 1'b1;
    wait_valid(60, n);
    check_eq("t3_forced_valid_d", valid_d, 1);
    check_eq("t3_forced_card", card_out, 10);
    check_eq("t3_forced_err", retry_err, 1);
    check_eq("t3_forced_src_on", on_cnt, 3);

    // T4 shoe exhaustion forces reshuffle before the 5th card
    do_reset();
    for (int i = 0; i < 4; i++) begin
      src_q.push_back(4'd2);
      req_d = 1'b1;
      wait_valid(40, n);
      check_eq("t4_deal_valid_d", valid_d, 1);
    end
    src_q.push_back(4'd8);
    req_d = 1'b1;
    step();
    check_eq("t4_full_dealt", dealt_cnt, 4);
    check_eq("t4_idle_gap", busy, 0);
    shuf_cnt = 0;
    step();
    check_eq("t4_shuffle_busy", shuffle_busy, 1);
    wait_valid(60, n);
    check_eq("t4_shuffle_len", shuf_cnt, 8);
    check_eq("t4_fifth_valid_d", valid_d, 1);
    check_eq("t4_fifth_card", card_out, 8);
    check_eq("t4_dealt_after_shuf", dealt_cnt, 0);
    step();
    check_eq("t4_dealt_one", dealt_cnt, 1);

    // T5 reset during WAIT aborts the draw
    do_reset();
    src_q = '{4'd6};
    req_p = 1'b1;
    step(); step(); step();
    check_eq("t5_in_wait", busy, 1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check_eq("t5_src_on", src_on, 0);
    check_eq("t5_busy", busy, 0);
    vacc = 0;
    on0 = on_cnt;
    for (int i = 0; i < 6; i++) begin
      step();
      vacc += int'(valid_p | valid_d);
    end
    check_eq("t5_no_valid", vacc, 0);
    check_eq("t5_no_src_on", on_cnt - on0, 0);
    check_eq("t5_dealt", dealt_cnt, 0);
    src_q = '{4'd8};
    req_p = 1'b1;
    wait_valid(40, n);
    check_eq("t5_next_latency", n, 5);
    check_eq("t5_next_card", card_out, 8);
    check_eq("t5_next_valid_p", valid_p, 1);

    // T6 new_shoe mid-draw: deliver first, reshuffle, then serve dealer
    do_reset();
    src_q = '{4'd4, 4'd9};
    req_p = 1'b1;
    step(); step(); step();
    new_shoe = 1'b1;
    wait_valid(40, n);
    check_eq("t6_valid_p", valid_p, 1);
    check_eq("t6_card", card_out, 4);
    shuf_cnt = 0;
    step();
    step();
    check_eq("t6_shuffle", shuffle_busy, 1);
    req_d = 1'b1;
    wait_valid(60, n);
    check_eq("t6_shuf_len", shuf_cnt, 8);
    check_eq("t6_valid_d", valid_d, 1);
    check_eq("t6_card_d", card_out, 9);
    check_eq("t6_dealt", dealt_cnt, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
